// File: rtl/ones_count_window_acc_pkg.sv
// Shared types and constants for the windowed ones-count accumulator.
//   acc_state_t : accumulator control states
//   OC_MAX      : largest count the upstream 3-input ones-count stage can emit
package ones_count_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } acc_state_t;

   localparam logic [1:0] OC_MAX = 2'd3;

endpackage

// File: rtl/ones_count_window_acc_sat_add.sv
// Saturating adder: running sum plus one 2-bit ones count.
//   a   : current sum (SUM_W bits)
//   b   : per-sample count y1:y0 (0..OC_MAX)
//   y   : a+b, clamped to all-ones on overflow
//   ovf : high when the clamp was applied
module ones_count_sat_add
   import ones_count_pkg::*;
#(
   parameter int SUM_W = 8
) (
   input  logic [SUM_W-1:0]         a,
   input  logic [$bits(OC_MAX)-1:0] b,
   output logic [SUM_W-1:0]         y,
   output logic                     ovf
);

   logic [SUM_W:0] w_wide;

   // One extra bit of headroom: the carry-out is exactly the overflow flag.
   always_comb begin
      w_wide = {1'b0, a} + (SUM_W + 1)'(b);
      ovf    = w_wide[SUM_W];
      y      = ovf ? '1 : w_wide[SUM_W-1:0];
   end

endmodule

// File: rtl/ones_count_window_acc.sv
// Accumulates the 2-bit ones count over a window of WINDOW valid samples and
// presents a saturating total with a done/ack result handshake.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   start              : open a new window (IDLE, or DONE together with ack)
//   in_valid, y1, y0   : sample strobe and its ones count
//   ack                : consumer has taken the result
//   busy / done        : window in progress / result held
//   sum, sat, samples  : saturating total, sticky clamp flag, samples taken
module ones_count_window_acc
   import ones_count_pkg::*;
#(
   parameter  int SUM_W  = 8,
   parameter  int WINDOW = 16,
   localparam int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             y1,
   input  logic             y0,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] sum,
   output logic             sat,
   output logic [CNT_W-1:0] samples
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WINDOW - 1);

   acc_state_t       r_state, w_nxt_state;
   logic [SUM_W-1:0] r_sum,   w_nxt_sum;
   logic             r_sat,   w_nxt_sat;
   logic [CNT_W-1:0] r_samples, w_nxt_samples;
   logic             r_busy,  r_done;

   logic [SUM_W-1:0] w_add_y;
   logic             w_add_ovf;

   ones_count_sat_add #(.SUM_W(SUM_W)) u_add (
      .a   (r_sum),
      .b   ({y1, y0}),
      .y   (w_add_y),
      .ovf (w_add_ovf)
   );

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_sum     = r_sum;
      w_nxt_sat     = r_sat;
      w_nxt_samples = r_samples;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nxt_state   = ACC;
               w_nxt_sum     = '0;
               w_nxt_sat     = 1'b0;
               w_nxt_samples = '0;
            end
         end
         ACC: begin
            if (in_valid) begin
               w_nxt_sum     = w_add_y;
               w_nxt_sat     = r_sat | w_add_ovf;
               w_nxt_samples = r_samples + CNT_W'(1);
               // The sample that completes the window is still accumulated.
               if (r_samples == LP_LAST) begin
                  w_nxt_state = DONE;
               end
            end
         end
         DONE: begin
            if (ack) begin
               if (start) begin
                  w_nxt_state   = ACC;
                  w_nxt_sum     = '0;
                  w_nxt_sat     = 1'b0;
                  w_nxt_samples = '0;
               end else begin
                  w_nxt_state = IDLE;
               end
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // busy/done are registered from the next state so every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sum     <= '0;
         r_sat     <= 1'b0;
         r_samples <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_sum     <= w_nxt_sum;
         r_sat     <= w_nxt_sat;
         r_samples <= w_nxt_samples;
         r_busy    <= (w_nxt_state == ACC);
         r_done    <= (w_nxt_state == DONE);
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign sum     = r_sum;
   assign sat     = r_sat;
   assign samples = r_samples;

endmodule
